// File: rtl/time_counter_if.sv
// Signal bundle between the time-of-day core and its user (display/set logic).
interface time_counter_if;
  logic       set_en;
  logic       btn_min;
  logic       btn_hour;
  logic [5:0] sec;
  logic [5:0] min;
  logic [5:0] hour;
  logic       sec_pulse;
  logic       day_pulse;

  modport master (
    output set_en, btn_min, btn_hour,
    input  sec, min, hour, sec_pulse, day_pulse
  );

  modport slave (
    input  set_en, btn_min, btn_hour,
    output sec, min, hour, sec_pulse, day_pulse
  );
endinterface

// File: rtl/time_counter.sv
// Time-of-day core: 1 Hz prescaler, sec/min/hour binary fields and
// set-mode increment buttons. All outputs come straight from registers.
module time_counter #(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic          clk,
  input  logic          rst_n,
  time_counter_if.slave bus
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;
  logic          tick;
  logic          btn_min_q;
  logic          btn_hour_q;
  logic          min_edge;
  logic          hour_edge;
  logic          sec_wrap;
  logic          min_wrap;
  logic          hour_wrap;
  logic [5:0]    sec_q;
  logic [5:0]    min_q;
  logic [5:0]    hour_q;
  logic          sec_pulse_q;
  logic          day_pulse_q;

  // tick only matters in run mode; set mode holds the prescaler at 0
  assign tick      = (count == TC);
  assign min_edge  = bus.btn_min  & ~btn_min_q;
  assign hour_edge = bus.btn_hour & ~btn_hour_q;
  assign sec_wrap  = (sec_q  == 6'd59);
  assign min_wrap  = (min_q  == 6'd59);
  assign hour_wrap = (hour_q == 6'd23);

  // prescaler: counts 0..TICK_DIV-1 in run mode, restarts from 0 out of set mode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (bus.set_en || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  // button history; reset to 1 so a button held through reset gives no edge
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      btn_min_q  <= 1'b1;
      btn_hour_q <= 1'b1;
    end else begin
      btn_min_q  <= bus.btn_min;
      btn_hour_q <= bus.btn_hour;
    end
  end

  // time fields: button increments in set mode, carry chain on tick in run mode
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
    end else if (bus.set_en) begin
      sec_q <= '0;
      if (min_edge) begin
        min_q <= min_wrap ? 6'd0 : min_q + 6'd1;
      end
      if (hour_edge) begin
        hour_q <= hour_wrap ? 6'd0 : hour_q + 6'd1;
      end
    end else if (tick) begin
      sec_q <= sec_wrap ? 6'd0 : sec_q + 6'd1;
      if (sec_wrap) begin
        min_q <= min_wrap ? 6'd0 : min_q + 6'd1;
        if (min_wrap) begin
          hour_q <= hour_wrap ? 6'd0 : hour_q + 6'd1;
        end
      end
    end
  end

  // strobes registered alongside the field update they announce
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sec_pulse_q <= 1'b0;
      day_pulse_q <= 1'b0;
    end else begin
      sec_pulse_q <= ~bus.set_en & tick;
      day_pulse_q <= ~bus.set_en & tick & sec_wrap & min_wrap & hour_wrap;
    end
  end

  assign bus.sec       = sec_q;
  assign bus.min       = min_q;
  assign bus.hour      = hour_q;
  assign bus.sec_pulse = sec_pulse_q;
  assign bus.day_pulse = day_pulse_q;

endmodule

// File: tb/tb_time_counter.sv
// Bench for time_counter with TICK_DIV = 4. A seconds-of-day reference model
// is stepped every clock edge and compared against the DUT each cycle.
module tb_time_counter;

  localparam int DIV = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  time_counter_if bus ();

  time_counter #(.TICK_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // reference model state
  int m_tod;
  int m_pre;
  int m_sp;
  int m_dp;
  bit m_hmin;
  bit m_hhour;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    int h, m;
    bit e_min, e_hour, tk;
    if (!rst_n) begin
      m_tod = 0; m_pre = 0; m_sp = 0; m_dp = 0;
      m_hmin = 1'b1; m_hhour = 1'b1;
    end else begin
      e_min  = bus.btn_min  && !m_hmin;
      e_hour = bus.btn_hour && !m_hhour;
      if (bus.set_en) begin
        h = m_tod / 3600;
        m = (m_tod / 60) % 60;
        if (e_min)  m = (m + 1) % 60;
        if (e_hour) h = (h + 1) % 24;
        m_tod = h * 3600 + m * 60;
        m_pre = 0; m_sp = 0; m_dp = 0;
      end else begin
        tk    = (m_pre == DIV - 1);
        m_pre = tk ? 0 : m_pre + 1;
        m_sp  = tk ? 1 : 0;
        m_dp  = (tk && m_tod == 86399) ? 1 : 0;
        if (tk) m_tod = (m_tod + 1) % 86400;
      end
      m_hmin  = bus.btn_min;
      m_hhour = bus.btn_hour;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("sec",       int'(bus.sec),       m_tod % 60);
    chk("min",       int'(bus.min),       (m_tod / 60) % 60);
    chk("hour",      int'(bus.hour),      m_tod / 3600);
    chk("sec_pulse", int'(bus.sec_pulse), m_sp);
    chk("day_pulse", int'(bus.day_pulse), m_dp);
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic press_min(input int n);
    for (int i = 0; i < n; i++) begin
      bus.btn_min = 1'b1; cycle();
      bus.btn_min = 1'b0; cycle();
    end
  endtask

  task automatic press_hour(input int n);
    for (int i = 0; i < n; i++) begin
      bus.btn_hour = 1'b1; cycle();
      bus.btn_hour = 1'b0; cycle();
    end
  endtask

  initial begin
    int pulses;
    int dps;
    rst_n = 1'b0;
    bus.set_en = 1'b0; bus.btn_min = 1'b0; bus.btn_hour = 1'b0;
    m_tod = 0; m_pre = 0; m_sp = 0; m_dp = 0; m_hmin = 1'b1; m_hhour = 1'b1;

    // reset then free run
    cycles(3);
    chk("rst_fields", int'({bus.hour, bus.min, bus.sec}), 0);
    rst_n = 1'b1;
    pulses = 0;
    for (int i = 1; i <= 40; i++) begin
      cycle();
      if (bus.sec_pulse) pulses++;
      if (i == 4) chk("first_tick_sec", int'(bus.sec), 1);
    end
    chk("run40_sec", int'(bus.sec), 10);
    chk("run40_pulses", pulses, 10);

    // preload 23:59 in set mode, run up to :58, then through midnight
    bus.set_en = 1'b1; cycle();
    press_hour(23);
    press_min(59);
    chk("preset_sec0", int'(bus.sec), 0);
    bus.set_en = 1'b0;
    cycles(58 * DIV);
    chk("pre_wrap", int'({bus.hour, bus.min, bus.sec}), int'({6'd23, 6'd59, 6'd58}));
    dps = 0;
    for (int i = 1; i <= 8; i++) begin
      cycle();
      if (bus.day_pulse) dps++;
      if (bus.min > 6'd59 || bus.hour > 6'd23) chk("field_range", 1, 0);
      if (i == 4) chk("at_59", int'(bus.sec), 59);
    end
    chk("wrap_time", int'({bus.hour, bus.min, bus.sec}), 0);
    chk("day_pulse_count", dps, 1);

    // 61 minute presses in set mode
    bus.set_en = 1'b1; cycle();
    press_min(61);
    chk("min61", int'(bus.min), 1);
    chk("min61_hour", int'(bus.hour), 0);
    chk("min61_sec", int'(bus.sec), 0);

    // held hour button counts once
    bus.btn_hour = 1'b1; cycles(10);
    bus.btn_hour = 1'b0; cycle();
    chk("hour_held", int'(bus.hour), 1);

    // simultaneous edges
    bus.btn_min = 1'b1; bus.btn_hour = 1'b1; cycle();
    chk("both_min", int'(bus.min), 2);
    chk("both_hour", int'(bus.hour), 2);
    bus.btn_min = 1'b0; bus.btn_hour = 1'b0; cycle();

    // buttons ignored in run mode
    bus.set_en = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.btn_min = ~bus.btn_min; cycle();
    end
    bus.btn_min = 1'b0;
    chk("run_btn_ignored", int'(bus.min), 2);

    // 12:34:56 then reset with btn_min held
    bus.set_en = 1'b1; cycle();
    press_hour(10);
    press_min(32);
    bus.set_en = 1'b0;
    cycles(56 * DIV);
    chk("pre_reset", int'({bus.hour, bus.min, bus.sec}), int'({6'd12, 6'd34, 6'd56}));
    bus.btn_min = 1'b1; cycle();
    rst_n = 1'b0; cycle();
    rst_n = 1'b1;
    chk("mid_reset", int'({bus.hour, bus.min, bus.sec}), 0);
    bus.set_en = 1'b1; cycles(5);
    chk("held_through_reset", int'(bus.min), 0);
    bus.btn_min = 1'b0; cycle();

    // randomized mix of modes, buttons and occasional resets
    for (int i = 0; i < 1500; i++) begin
      rst_n = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 19) == 0) bus.set_en = ~bus.set_en;
      bus.btn_min  = ($urandom_range(0, 2) == 0);
      bus.btn_hour = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
